// File: rtl/hdmi_pixel_fetch.sv
// hdmi_pixel_fetch: turns HDMI timing into image-memory read addresses and
// re-aligns the returned grey samples with the delayed syncs for the TX.
module hdmi_pixel_fetch #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned X0      = 192,
  parameter int unsigned Y0      = 112,
  parameter int unsigned MEM_LAT = 2,
  parameter logic [23:0] BORDER  = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] parallelAddress,
  output logic              rd_en,
  input  logic [7:0]        q,
  output logic [23:0]       rgb_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int unsigned L  = MEM_LAT + 2;
  localparam int unsigned CW = 12;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW:0]   X_LO    = (CW+1)'(X0);
  localparam logic [CW:0]   X_HI    = (CW+1)'(X0 + IMG_W);
  localparam logic [CW:0]   Y_LO    = (CW+1)'(Y0);
  localparam logic [CW:0]   Y_HI    = (CW+1)'(Y0 + IMG_H);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              vs_prev_q, vs_prev_d;
  logic              de_prev_q, de_prev_d;
  logic [CW-1:0]     x_q, x_d;
  logic [CW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_LAT:0]  win_pipe_q, win_pipe_d;
  logic [L-1:0]      de_pipe_q, de_pipe_d;
  logic [L-1:0]      hs_pipe_q, hs_pipe_d;
  logic [L-1:0]      vs_pipe_q, vs_pipe_d;
  logic [23:0]       rgb_q, rgb_d;

  logic              vs_rise;
  logic              de_fall;
  logic              live;
  logic              win;
  logic [CW-1:0]     x_cur;
  logic [CW-1:0]     y_cur;
  logic [ADDR_W-1:0] base_cur;
  logic [ADDR_W-1:0] x_rel;
  logic [ADDR_W-1:0] y_rel;
  logic [ADDR_W-1:0] addr_calc;

  // Position tracking, frame base capture, window test and address generation.
  // A vs rise substitutes the new-frame values (x=y=0, base=offset) into this
  // same cycle so a coincident DE pixel is pixel 0 and a coincident DE fall
  // cannot bump y.
  always_comb begin
    vs_rise   = vs_in & ~vs_prev_q;
    de_fall   = ~de_in & de_prev_q;
    live      = (state_q == SYNC) | vs_rise;
    x_cur     = vs_rise ? '0 : x_q;
    y_cur     = vs_rise ? '0 : y_q;
    base_cur  = vs_rise ? offset : base_q;

    state_d   = vs_rise ? SYNC : state_q;
    vs_prev_d = vs_in;
    de_prev_d = de_in;
    base_d    = base_cur;

    x_d = x_cur;
    y_d = y_cur;
    if (!live) begin
      x_d = '0;
      y_d = '0;
    end else if (de_in) begin
      x_d = (x_cur == CNT_MAX) ? x_cur : x_cur + CW'(1);
    end else if (de_fall && !vs_rise) begin
      x_d = '0;
      y_d = (y_cur == CNT_MAX) ? y_cur : y_cur + CW'(1);
    end

    win = de_in & live &
          ({1'b0, x_cur} >= X_LO) & ({1'b0, x_cur} < X_HI) &
          ({1'b0, y_cur} >= Y_LO) & ({1'b0, y_cur} < Y_HI);

    // Constant multiply: a shift for power-of-two widths, a small constant
    // adder tree otherwise; the modulo-2^ADDR_W result is the same either way.
    x_rel     = ADDR_W'(x_cur - CW'(X0));
    y_rel     = ADDR_W'(y_cur - CW'(Y0));
    addr_calc = base_cur + y_rel * ADDR_W'(IMG_W) + x_rel;
    addr_d    = win ? addr_calc : addr_q;
  end

  // Delay lines for the window flag and the syncs, plus the output colour mux.
  always_comb begin
    win_pipe_d = {win_pipe_q[MEM_LAT-1:0], win};
    de_pipe_d  = {de_pipe_q[L-2:0], de_in & live};
    hs_pipe_d  = {hs_pipe_q[L-2:0], hs_in};
    vs_pipe_d  = {vs_pipe_q[L-2:0], vs_in};
    rgb_d      = '0;
    if (de_pipe_q[L-2]) begin
      rgb_d = win_pipe_q[MEM_LAT] ? {q, q, q} : BORDER;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= UNSYNC;
      vs_prev_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      win_pipe_q <= '0;
      de_pipe_q  <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      vs_prev_q  <= vs_prev_d;
      de_prev_q  <= de_prev_d;
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      win_pipe_q <= win_pipe_d;
      de_pipe_q  <= de_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      rgb_q      <= rgb_d;
    end
  end

  assign parallelAddress = addr_q;
  assign rd_en           = win_pipe_q[0];
  assign rgb_out         = rgb_q;
  assign de_out          = de_pipe_q[L-1];
  assign hs_out          = hs_pipe_q[L-1];
  assign vs_out          = vs_pipe_q[L-1];

endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Directed bench for hdmi_pixel_fetch: instance A uses MEM_LAT=2 (L=4),
// instance B uses MEM_LAT=4 (L=6) with a visible border colour. Each instance
// gets a memory model returning q = addr[7:0] MEM_LAT cycles after the address.
// Inputs are driven just after the rising edge of period p and all signals are
// recorded at the falling edge of period p, so a pixel driven in period p shows
// its address in period p+1 and its colour in period p+L.
module tb_hdmi_pixel_fetch;
  localparam int MAXP = 32768;
  localparam logic [23:0] BORDER_B = 24'hA5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [17:0] offset = '0;

  logic [17:0] addr_a, addr_b;
  logic        rd_a, rd_b, deo_a, deo_b, hso_a, hso_b, vso_a, vso_b;
  logic [23:0] rgb_a, rgb_b;
  logic [7:0]  q_a, q_b;

  logic [17:0] qa1 = '0, qa2 = '0;
  logic [17:0] qb1 = '0, qb2 = '0, qb3 = '0, qb4 = '0;

  logic        h_de [MAXP];
  logic        h_hs [MAXP];
  logic        h_vs [MAXP];
  logic [17:0] h_addr_a [MAXP];
  logic [17:0] h_addr_b [MAXP];
  logic        h_rd_a [MAXP];
  logic        h_rd_b [MAXP];
  logic [23:0] h_rgb_a [MAXP];
  logic [23:0] h_rgb_b [MAXP];
  logic        h_deo_a [MAXP];
  logic        h_deo_b [MAXP];
  logic        h_hso_a [MAXP];
  logic        h_hso_b [MAXP];
  logic        h_vso_a [MAXP];
  logic        h_vso_b [MAXP];

  int p = 0;
  int ls [4][512];
  int fs [4];
  int fe1 = 0;
  int nvec = 0;
  int nerr = 0;

  hdmi_pixel_fetch #(.ADDR_W(18), .MEM_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .offset(offset), .parallelAddress(addr_a), .rd_en(rd_a), .q(q_a),
    .rgb_out(rgb_a), .de_out(deo_a), .hs_out(hso_a), .vs_out(vso_a)
  );

  hdmi_pixel_fetch #(.ADDR_W(18), .MEM_LAT(4), .BORDER(BORDER_B)) u_dut_b (
    .clk(clk), .rst(rst), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
    .offset(offset), .parallelAddress(addr_b), .rd_en(rd_b), .q(q_b),
    .rgb_out(rgb_b), .de_out(deo_b), .hs_out(hso_b), .vs_out(vso_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    qa1 <= addr_a; qa2 <= qa1;
    qb1 <= addr_b; qb2 <= qb1; qb3 <= qb2; qb4 <= qb3;
  end
  assign q_a = qa2[7:0];
  assign q_b = qb4[7:0];

  task automatic step(input logic de, input logic hs, input logic vs);
    @(posedge clk); #1;
    de_in = de; hs_in = hs; vs_in = vs;
    @(negedge clk);
    if (p < MAXP) begin
      h_de[p] = de; h_hs[p] = hs; h_vs[p] = vs;
      h_addr_a[p] = addr_a; h_addr_b[p] = addr_b;
      h_rd_a[p] = rd_a; h_rd_b[p] = rd_b;
      h_rgb_a[p] = rgb_a; h_rgb_b[p] = rgb_b;
      h_deo_a[p] = deo_a; h_deo_b[p] = deo_b;
      h_hso_a[p] = hso_a; h_hso_b[p] = hso_b;
      h_vso_a[p] = vso_a; h_vso_b[p] = vso_b;
    end
    p++;
  endtask

  // Only a few lines are long enough to reach the window columns; the rest
  // carry a single DE cycle so y still advances cheaply.
  task automatic drive_line(input int f, input int y);
    int len;
    len = (y == 112 || y == 113 || y == 200 || y == 367 || y == 368) ? 460 : 1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ls[f][y] = p;
    repeat (len) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_lines(input int f, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) drive_line(f, y);
  endtask

  task automatic frame_head(input int f);
    fs[f] = p;
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (addr_a !== 18'h0) begin nerr++; $display("FAIL reset_addr_a: got %h want 0", addr_a); end
    nvec++; if (rd_a !== 1'b0) begin nerr++; $display("FAIL reset_rd_a: got %b want 0", rd_a); end
    nvec++; if (rgb_a !== 24'h0) begin nerr++; $display("FAIL reset_rgb_a: got %h want 0", rgb_a); end
    nvec++; if (deo_a !== 1'b0) begin nerr++; $display("FAIL reset_de_a: got %b want 0", deo_a); end
    nvec++; if (hso_a !== 1'b0) begin nerr++; $display("FAIL reset_hs_a: got %b want 0", hso_a); end
    nvec++; if (vso_a !== 1'b0) begin nerr++; $display("FAIL reset_vs_a: got %b want 0", vso_a); end
    nvec++; if (addr_b !== 18'h0) begin nerr++; $display("FAIL reset_addr_b: got %h want 0", addr_b); end
    nvec++; if (rd_b !== 1'b0) begin nerr++; $display("FAIL reset_rd_b: got %b want 0", rd_b); end
    nvec++; if (rgb_b !== 24'h0) begin nerr++; $display("FAIL reset_rgb_b: got %h want 0", rgb_b); end
    nvec++; if (deo_b !== 1'b0) begin nerr++; $display("FAIL reset_de_b: got %b want 0", deo_b); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_unsync;
    int p0;
    p0 = p;
    drive_line(0, 0);
    drive_line(0, 1);
    drive_line(0, 2);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    for (int k = p0; k < p; k++) begin
      nvec++;
      if (h_deo_a[k] !== 1'b0 || h_deo_b[k] !== 1'b0 || h_rd_a[k] !== 1'b0) begin
        nerr++;
        $display("FAIL unsync_blank: period %0d de_a=%b de_b=%b rd_a=%b want 0", k, h_deo_a[k], h_deo_b[k], h_rd_a[k]);
      end
    end
    nvec++; if (h_hso_a[p0+4] !== 1'b1) begin nerr++; $display("FAIL unsync_hs_a: got %b want 1", h_hso_a[p0+4]); end
    nvec++; if (h_hso_b[p0+6] !== 1'b1) begin nerr++; $display("FAIL unsync_hs_b: got %b want 1", h_hso_b[p0+6]); end
  endtask

  task automatic test_first_frame;
    int pa, pb, pc, pd, pe;
    offset = 18'h00000;
    frame_head(0);
    drive_lines(0, 0, 149);
    offset = 18'h3FF00;
    drive_lines(0, 150, 369);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    pa = ls[0][112] + 192;
    nvec++; if (h_rd_a[pa] !== 1'b0) begin nerr++; $display("FAIL x191_rd: got %b want 0", h_rd_a[pa]); end
    nvec++; if (h_rd_a[pa+1] !== 1'b1) begin nerr++; $display("FAIL first_rd: got %b want 1", h_rd_a[pa+1]); end
    nvec++; if (h_addr_a[pa+1] !== 18'h0) begin nerr++; $display("FAIL first_addr: got %h want 0", h_addr_a[pa+1]); end
    nvec++; if (h_addr_a[pa+2] !== 18'h1) begin nerr++; $display("FAIL second_addr: got %h want 1", h_addr_a[pa+2]); end
    nvec++; if (h_addr_b[pa+1] !== 18'h0) begin nerr++; $display("FAIL first_addr_b: got %h want 0", h_addr_b[pa+1]); end
    nvec++; if (h_deo_a[pa+4] !== 1'b1) begin nerr++; $display("FAIL first_de: got %b want 1", h_deo_a[pa+4]); end
    nvec++; if (h_rgb_a[pa+4] !== 24'h000000) begin nerr++; $display("FAIL first_rgb: got %h want 000000", h_rgb_a[pa+4]); end
    nvec++; if (h_rgb_a[pa+5] !== 24'h010101) begin nerr++; $display("FAIL second_rgb: got %h want 010101", h_rgb_a[pa+5]); end
    nvec++; if (h_rgb_b[pa+5] !== BORDER_B) begin nerr++; $display("FAIL x191_border_b: got %h want %h", h_rgb_b[pa+5], BORDER_B); end
    nvec++; if (h_rgb_b[pa+6] !== 24'h000000) begin nerr++; $display("FAIL first_rgb_b: got %h want 000000", h_rgb_b[pa+6]); end
    nvec++; if (h_rgb_b[pa+7] !== 24'h010101) begin nerr++; $display("FAIL second_rgb_b: got %h want 010101", h_rgb_b[pa+7]); end
    pb = ls[0][113] + 200;
    nvec++; if (h_addr_a[pb+1] !== 18'd264) begin nerr++; $display("FAIL addr_113_200: got %0d want 264", h_addr_a[pb+1]); end
    nvec++; if (h_rgb_a[pb+4] !== 24'h080808) begin nerr++; $display("FAIL rgb_113_200: got %h want 080808", h_rgb_a[pb+4]); end
    pc = ls[0][367] + 447;
    nvec++; if (h_addr_a[pc+1] !== 18'd65535) begin nerr++; $display("FAIL last_addr: got %0d want 65535", h_addr_a[pc+1]); end
    nvec++; if (h_rd_a[pc+1] !== 1'b1) begin nerr++; $display("FAIL last_rd: got %b want 1", h_rd_a[pc+1]); end
    nvec++; if (h_rd_a[pc+2] !== 1'b0) begin nerr++; $display("FAIL x448_rd: got %b want 0", h_rd_a[pc+2]); end
    nvec++; if (h_addr_a[pc+2] !== 18'd65535) begin nerr++; $display("FAIL x448_addr_hold: got %0d want 65535", h_addr_a[pc+2]); end
    nvec++; if (h_rgb_a[pc+4] !== 24'hFFFFFF) begin nerr++; $display("FAIL last_rgb: got %h want FFFFFF", h_rgb_a[pc+4]); end
    nvec++; if (h_deo_a[pc+5] !== 1'b1) begin nerr++; $display("FAIL x448_de: got %b want 1", h_deo_a[pc+5]); end
    nvec++; if (h_rgb_a[pc+5] !== 24'h000000) begin nerr++; $display("FAIL x448_border: got %h want 000000", h_rgb_a[pc+5]); end
    nvec++; if (h_rgb_b[pc+6] !== 24'hFFFFFF) begin nerr++; $display("FAIL last_rgb_b: got %h want FFFFFF", h_rgb_b[pc+6]); end
    nvec++; if (h_rgb_b[pc+7] !== BORDER_B) begin nerr++; $display("FAIL x448_border_b: got %h want %h", h_rgb_b[pc+7], BORDER_B); end
    pd = ls[0][368] + 300;
    nvec++; if (h_rd_a[pd+1] !== 1'b0) begin nerr++; $display("FAIL y368_rd: got %b want 0", h_rd_a[pd+1]); end
    pe = ls[0][200] + 192;
    nvec++; if (h_addr_a[pe+1] !== 18'h05800) begin nerr++; $display("FAIL midframe_offset_addr: got %h want 05800", h_addr_a[pe+1]); end
    nvec++; if (h_rgb_a[pe+5] !== 24'h010101) begin nerr++; $display("FAIL midframe_offset_rgb: got %h want 010101", h_rgb_a[pe+5]); end
  endtask

  task automatic test_offset_frame;
    int pa, pb;
    frame_head(1);
    drive_lines(1, 0, 369);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    fe1 = p;
    pa = ls[1][112] + 192;
    nvec++; if (h_addr_a[pa+1] !== 18'h3FF00) begin nerr++; $display("FAIL new_base_addr: got %h want 3ff00", h_addr_a[pa+1]); end
    nvec++; if (h_rd_a[pa+1] !== 1'b1) begin nerr++; $display("FAIL new_base_rd: got %b want 1", h_rd_a[pa+1]); end
    pb = ls[1][113] + 192;
    nvec++; if (h_addr_a[pb+1] !== 18'h00000) begin nerr++; $display("FAIL wrap_addr: got %h want 00000", h_addr_a[pb+1]); end
    nvec++; if (h_addr_a[pb+2] !== 18'h00001) begin nerr++; $display("FAIL wrap_addr_next: got %h want 00001", h_addr_a[pb+2]); end
    nvec++; if (h_addr_b[pb+1] !== 18'h00000) begin nerr++; $display("FAIL wrap_addr_b: got %h want 00000", h_addr_b[pb+1]); end
    nvec++; if (h_rgb_a[pb+5] !== 24'h010101) begin nerr++; $display("FAIL wrap_rgb: got %h want 010101", h_rgb_a[pb+5]); end
    nvec++; if (h_rgb_b[pb+7] !== 24'h010101) begin nerr++; $display("FAIL wrap_rgb_b: got %h want 010101", h_rgb_b[pb+7]); end
  endtask

  task automatic test_sync_delay;
    for (int k = fs[1] + 6; k < fe1; k++) begin
      nvec++;
      if (h_deo_a[k] !== h_de[k-4] || h_hso_a[k] !== h_hs[k-4] || h_vso_a[k] !== h_vs[k-4]) begin
        nerr++;
        $display("FAIL sync_a period %0d: got de/hs/vs=%b%b%b want %b%b%b", k, h_deo_a[k], h_hso_a[k], h_vso_a[k], h_de[k-4], h_hs[k-4], h_vs[k-4]);
      end
      nvec++;
      if (h_deo_b[k] !== h_de[k-6] || h_hso_b[k] !== h_hs[k-6] || h_vso_b[k] !== h_vs[k-6]) begin
        nerr++;
        $display("FAIL sync_b period %0d: got de/hs/vs=%b%b%b want %b%b%b", k, h_deo_b[k], h_hso_b[k], h_vso_b[k], h_de[k-6], h_hs[k-6], h_vs[k-6]);
      end
      if (h_deo_a[k] === 1'b0) begin
        nvec++;
        if (h_rgb_a[k] !== 24'h0) begin nerr++; $display("FAIL blank_rgb_a period %0d: got %h want 0", k, h_rgb_a[k]); end
      end
      if (h_deo_b[k] === 1'b0) begin
        nvec++;
        if (h_rgb_b[k] !== 24'h0) begin nerr++; $display("FAIL blank_rgb_b period %0d: got %h want 0", k, h_rgb_b[k]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int rp, pa;
    frame_head(2);
    drive_lines(2, 0, 199);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    ls[2][200] = p;
    repeat (100) step(1'b1, 1'b0, 1'b0);
    nvec++; if (deo_a !== 1'b1) begin nerr++; $display("FAIL pre_reset_de: got %b want 1", deo_a); end
    #2 rst = 1'b0;
    #1;
    nvec++; if (deo_a !== 1'b0 || deo_b !== 1'b0) begin nerr++; $display("FAIL async_de: got %b%b want 00", deo_a, deo_b); end
    nvec++; if (rd_a !== 1'b0 || rd_b !== 1'b0) begin nerr++; $display("FAIL async_rd: got %b%b want 00", rd_a, rd_b); end
    nvec++; if (rgb_a !== 24'h0 || rgb_b !== 24'h0) begin nerr++; $display("FAIL async_rgb: got %h %h want 0", rgb_a, rgb_b); end
    nvec++; if (addr_a !== 18'h0 || addr_b !== 18'h0) begin nerr++; $display("FAIL async_addr: got %h %h want 0", addr_a, addr_b); end
    rp = p;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    repeat (357) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    drive_lines(2, 201, 369);
    frame_head(3);
    for (int k = rp; k < fs[3] + 4; k++) begin
      nvec++;
      if (h_deo_a[k] !== 1'b0 || h_deo_b[k] !== 1'b0 || h_rd_a[k] !== 1'b0 || h_rgb_a[k] !== 24'h0) begin
        nerr++;
        $display("FAIL post_reset_blank period %0d: de_a=%b de_b=%b rd_a=%b rgb_a=%h want 0", k, h_deo_a[k], h_deo_b[k], h_rd_a[k], h_rgb_a[k]);
      end
    end
    drive_lines(3, 0, 113);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    pa = ls[3][112] + 192;
    nvec++; if (h_rd_a[pa+1] !== 1'b1) begin nerr++; $display("FAIL resync_rd: got %b want 1", h_rd_a[pa+1]); end
    nvec++; if (h_addr_a[pa+1] !== 18'h3FF00) begin nerr++; $display("FAIL resync_addr: got %h want 3ff00", h_addr_a[pa+1]); end
    nvec++; if (h_deo_a[pa+4] !== 1'b1) begin nerr++; $display("FAIL resync_de: got %b want 1", h_deo_a[pa+4]); end
    nvec++; if (h_rgb_a[pa+5] !== 24'h010101) begin nerr++; $display("FAIL resync_rgb: got %h want 010101", h_rgb_a[pa+5]); end
    nvec++; if (h_rgb_b[pa+7] !== 24'h010101) begin nerr++; $display("FAIL resync_rgb_b: got %h want 010101", h_rgb_b[pa+7]); end
  endtask

  initial begin
    test_reset();
    test_unsync();
    test_first_frame();
    test_offset_frame();
    test_sync_delay();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
